// File: rtl/mips_run_if.sv
// Bundles the control and status signals that pass between the MIPS run
// controller and whoever drives it (board logic or a bench).
//   step_mode   : 1 = single-step, 0 = free-run
//   step_req    : level; each 0->1 transition grants one core cycle in step mode
//   halt_req    : core-side halt request, sampled every cycle
//   core_rst    : active-high reset to the MIPS core
//   core_ce     : clock enable to the MIPS core
//   cycle_count : number of cycles with core_ce=1 since reset (saturating)
//   running     : 1 while the core is being clocked (RUN or STEP)
//   done        : 1 once halted or timed out
//   timeout     : 1 only after the cycle budget ran out
interface mips_run_if #(
    parameter int CNT_W = 16
);
    logic             step_mode;
    logic             step_req;
    logic             halt_req;
    logic             core_rst;
    logic             core_ce;
    logic [CNT_W-1:0] cycle_count;
    logic             running;
    logic             done;
    logic             timeout;

    modport master (
        output step_mode, step_req, halt_req,
        input  core_rst, core_ce, cycle_count, running, done, timeout
    );

    modport slave (
        input  step_mode, step_req, halt_req,
        output core_rst, core_ce, cycle_count, running, done, timeout
    );
endinterface

// File: rtl/mips_run_controller.sv
// Run/reset controller for the MIPS core. Synchronises the release of the
// board reset, holds the core in reset for RESET_CYCLES more cycles, then
// gates the core clock enable according to free-run / single-step mode, an
// external halt request and an optional cycle budget.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mips_run_if.slave (mode/step/halt in, core_rst/core_ce/status out)
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_HOLD    | core held in reset, waiting for sync release + hold time
// S_RUN     | free-running, core_ce=1
// S_SWAIT   | step mode, core stopped, waiting for a step_req rising edge
// S_STEP    | one granted core cycle, core_ce=1
// S_HALTED  | stopped by halt_req, terminal until reset
// S_TIMEOUT | cycle budget exhausted, terminal until reset
module mips_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 50,
    parameter int CNT_W        = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    mips_run_if.slave  bus
);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W:0]   HOLD_TGT = (HOLD_W + 1)'(RESET_CYCLES);
    localparam logic [CNT_W:0]    MAX_TGT  = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_SWAIT,
        S_STEP,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   step_prev_q;
    logic [CNT_W-1:0]       cnt_q;

    logic rst_rel;
    logic hold_done;
    logic budget_hit;
    logic step_rise;
    logic counting;

    assign rst_rel    = sync_q[SYNC_STAGES-1];
    assign hold_done  = rst_rel && (({1'b0, hold_q} + {{HOLD_W{1'b0}}, 1'b1}) == HOLD_TGT);
    // Budget is judged on the count this cycle will produce, so the core gets
    // exactly MAX_CYCLES enabled cycles.
    assign budget_hit = (MAX_CYCLES != 0) &&
                        (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == MAX_TGT);
    assign step_rise  = bus.step_req && !step_prev_q;
    assign counting   = (state_q == S_RUN) || (state_q == S_STEP);

    // Reset-release synchroniser, hold counter, step edge detect, cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            hold_q      <= '0;
            step_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            step_prev_q <= bus.step_req;
            if (state_q == S_HOLD && rst_rel) begin
                hold_q <= hold_q + HOLD_ONE;
            end
            if (counting && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: begin
                if (hold_done) state_d = S_RUN;
            end
            // RUN and STEP share one exit rule: STEP simply falls back to
            // SWAIT (or RUN if step mode was dropped) after its single cycle.
            S_RUN, S_STEP: begin
                if (bus.halt_req)       state_d = S_HALTED;
                else if (budget_hit)    state_d = S_TIMEOUT;
                else if (bus.step_mode) state_d = S_SWAIT;
                else                    state_d = S_RUN;
            end
            S_SWAIT: begin
                if (bus.halt_req)        state_d = S_HALTED;
                else if (!bus.step_mode) state_d = S_RUN;
                else if (step_rise)      state_d = S_STEP;
            end
            S_HALTED, S_TIMEOUT: state_d = state_q;
            default: state_d = S_HOLD;
        endcase
    end

    always_comb begin
        bus.core_rst    = (state_q == S_HOLD);
        bus.core_ce     = counting;
        bus.running     = counting;
        bus.done        = (state_q == S_HALTED) || (state_q == S_TIMEOUT);
        bus.timeout     = (state_q == S_TIMEOUT);
        bus.cycle_count = cnt_q;
    end
endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
Parametrised run/reset controller for the MIPS core. It generalises the fixed clock/reset sequencing used around the core into a synthesizable block with these features:
- synchronised reset release with a programmable hold time
- a cycle budget with timeout
- an external halt
- single-step mode

It sits between the board/bench reset and the MIPS core's reset and clock-enable inputs.

Parameters:
RESET_CYCLES, 2, core_rst held this many clk cycles after the synchroniser releases (min 1)
MAX_CYCLES, 50, core-enabled cycle budget before timeout; 0 = unlimited
CNT_W, 16, width of cycle_count
SYNC_STAGES, 2, reset-release synchroniser depth (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
step_mode  input  1  1 = single-step mode, 0 = free-run
step_req  input  1  level; each 0->1 transition grants one core cycle in step mode
halt_req  input  1  core-side halt request (e.g. break/syscall), sampled each cycle
core_rst  output  1  active-high reset to the MIPS core
core_ce  output  1  clock enable to the MIPS core
cycle_count  output  CNT_W  number of cycles with core_ce=1 since reset
running  output  1  1 in RUN or STEP states
done  output  1  1 in HALTED or TIMEOUT
timeout  output  1  1 only in TIMEOUT

Behaviour:
- Reset (reset=0, async): sync chain cleared, state=HOLD.
  - Outputs: core_rst=1, core_ce=0, cycle_count=0, running=0, done=0, timeout=0.
  - Hold counter and step edge register are cleared.
  - Asserting reset mid-operation from any state returns here immediately.
- Synchroniser: shifts in 1 each edge while reset=1. rst_rel goes high on the SYNC_STAGES-th rising edge after reset rises.
- HOLD: the hold counter increments each edge with rst_rel=1. On reaching RESET_CYCLES, the block goes to RUN and core_rst becomes 0 at that same edge.
  - Defaults: core_rst falls on edge 4 after reset release.
- Outputs are registered Moore outputs of the state:
  - core_ce=1 in RUN and STEP, else 0.
  - core_rst=1 only in HOLD.
- RUN, evaluated in priority order:
  1. halt_req=1 -> HALTED
  2. budget hit -> TIMEOUT
  3. step_mode=1 -> SWAIT
  4. otherwise stay in RUN
- Every edge leaving RUN or STEP counts that cycle: cycle_count += 1.
- Budget hit means MAX_CYCLES!=0 and cycle_count+1 == MAX_CYCLES at that edge.
- Simultaneous halt_req and budget hit -> HALTED with timeout=0 (halt wins).
- SWAIT: core_ce=0.
  - step_mode=0 -> RUN.
  - Rising edge of step_req (registered prev value) -> STEP.
  - halt_req -> HALTED (halt wins over step).
- STEP: lasts exactly one cycle with core_ce=1 and counts once. Next state uses the same priority as RUN, except the default is SWAIT while step_mode=1.
  - A held-high step_req grants only one step.
  - A new step needs step_req to go low and then high again.
- HALTED / TIMEOUT: terminal until reset.
  - core_ce=0, done=1, cycle_count frozen.
  - timeout=1 in TIMEOUT only.
  - halt_req and step_req are ignored.
- cycle_count saturates at 2^CNT_W-1 and never wraps. With MAX_CYCLES=0 the core keeps running after saturation.
- step_mode=1 already set at HOLD exit: the block still enters RUN for 1 cycle (counted), then SWAIT.

Test Plan:
1. Defaults, reset low 2 cycles then high, idle inputs:
   - core_rst=1 through edge 3, 0 from edge 4.
   - core_ce=1 for exactly 50 cycles.
   - Then timeout=1, done=1, core_ce=0, cycle_count=50.
2. halt_req pulsed 1 cycle when cycle_count=10:
   - HALTED, cycle_count=11, done=1, timeout=0, core_ce=0 next cycle.
   - A later halt_req or step_req has no effect.
3. Halt at budget: halt_req=1 in the cycle where cycle_count=49 -> HALTED, cycle_count=50, timeout=0.
4. Step mode: step_mode=1 from reset; three step_req pulses plus one step_req held high 5 cycles:
   - Exactly 4 single-cycle core_ce pulses.
   - cycle_count=5 (includes the 1 RUN cycle).
   - step_mode=0 then resumes free-run.
5. Reset asserted asynchronously mid-RUN (cycle_count=20, between clock edges):
   - core_rst=1, core_ce=0, cycle_count=0, done=0 immediately without a clock edge.
   - Release repeats the scenario 1 timing.
6. MAX_CYCLES=0, CNT_W=4:
   - Runs with no timeout; cycle_count saturates at 15 and holds.
   - core_ce stays 1, done=0.
